// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: 4x4 keypad scanner with debounce and two-digit hex byte assembly.
// Ports: i_clk/i_rst_n clock and async active-low reset; o_row/i_col active-low keypad matrix;
// o_key_valid/o_key accepted key pulse and code; o_entry partial byte; i_clear aborts entry;
// o_byte_valid/o_byte/i_byte_ready completed-byte handshake; o_overrun pulses when a byte is dropped.
module keypad_hex_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [3:0] o_row,
    input  logic [3:0] i_col,
    input  logic       i_clear,
    output logic       o_key_valid,
    output logic [3:0] o_key,
    output logic [7:0] o_entry,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    input  logic       i_byte_ready,
    output logic       o_overrun
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
    state_t      state, state_n;
    logic [3:0]  col_meta, col_sync, col_lat, col_lat_n;
    logic [15:0] period;
    logic [1:0]  row, row_n, col_idx;
    logic [7:0]  match, match_n;
    logic        sample, one_low, accept, phase;
    logic [3:0]  key_code;

    assign sample   = period == 16'(SCAN_DIV - 1);
    assign one_low  = (col_sync == 4'b1110) || (col_sync == 4'b1101) ||
                      (col_sync == 4'b1011) || (col_sync == 4'b0111);
    assign col_idx  = !col_sync[0] ? 2'd0 : !col_sync[1] ? 2'd1 : !col_sync[2] ? 2'd2 : 2'd3;
    assign key_code = {row, col_idx};
    assign o_row    = ~(4'b0001 << row);

    // match doubles as the press-match count in DEBOUNCE and the release count in HELD
    always_comb begin
        state_n   = state;
        row_n     = row;
        col_lat_n = col_lat;
        match_n   = match;
        accept    = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (one_low) begin
                        col_lat_n = col_sync;
                        match_n   = 8'd1;
                        if (DEBOUNCE_CNT == 1) begin
                            accept  = 1'b1;
                            state_n = HELD;
                            match_n = 8'd0;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        row_n = row + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_sync == col_lat) begin
                        match_n = match + 8'd1;
                        if (match + 8'd1 == 8'(DEBOUNCE_CNT)) begin
                            accept  = 1'b1;
                            state_n = HELD;
                            match_n = 8'd0;
                        end
                    end else begin
                        state_n = SCAN;
                        row_n   = row + 2'd1;
                    end
                end
                HELD: begin
                    if (col_sync == 4'hF) begin
                        match_n = match + 8'd1;
                        if (match + 8'd1 == 8'(DEBOUNCE_CNT)) begin
                            state_n = SCAN;
                            row_n   = row + 2'd1;
                            match_n = 8'd0;
                        end
                    end else begin
                        match_n = 8'd0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= SCAN;
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            col_lat  <= 4'hF;
            period   <= '0;
            row      <= '0;
            match    <= '0;
        end else begin
            state    <= state_n;
            col_meta <= i_col;
            col_sync <= col_meta;
            col_lat  <= col_lat_n;
            period   <= sample ? 16'd0 : period + 16'd1;
            row      <= row_n;
            match    <= match_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_key_valid  <= 1'b0;
            o_key        <= '0;
            o_entry      <= '0;
            phase        <= 1'b0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_key_valid <= accept;
            o_overrun   <= 1'b0;
            if (accept) o_key <= key_code;
            if (o_byte_valid && i_byte_ready) o_byte_valid <= 1'b0;
            if (i_clear) begin
                o_entry <= '0;
                phase   <= 1'b0;
            end else if (accept && !phase) begin
                o_entry <= {key_code, 4'h0};
                phase   <= 1'b1;
            end else if (accept) begin
                o_entry <= '0;
                phase   <= 1'b0;
                // a consumer taking the old byte this cycle frees the slot for the new one
                if (!o_byte_valid || i_byte_ready) begin
                    o_byte       <= {o_entry[7:4], key_code};
                    o_byte_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end
        end
    end
endmodule
